// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core and the data-memory responder.
// The core drives the master side; the responder sits on the slave side.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_size,
      output req_unsigned,
      output req_wdata,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  rsp_error,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_size,
      input  req_unsigned,
      input  req_wdata,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output rsp_error,
      output busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready load/store over a 64-bit LE word array.
// Build option DATA_MEM_MISALIGN_CHECK_EN: misaligned accesses return an error.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned IW =
      (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) << 3;
   localparam logic [3:0]  CNT_INIT =
      (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        write_q, write_d;
   logic        uns_q, uns_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [63:0] mem [DEPTH_WORDS];

   logic [2:0]    low_bits;
   logic [7:0]    size_mask;
   logic          misaligned;
   logic [63:0]   addr_eff;
   logic [2:0]    lane;
   logic [IW-1:0] idx;
   logic          acc_err;
   logic [63:0]   word;
   logic [63:0]   shifted;
   logic [63:0]   load_val;
   logic [7:0]    wmask;
   logic [63:0]   wdata_sh;

   assign bus.req_ready = (state_q == S_IDLE) && !reset;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = err_q;
   assign bus.busy      = (state_q != S_IDLE);

   // Address decode, lane shifting and load extension for the latched request.
   always_comb begin
      low_bits  = 3'b000;
      size_mask = 8'h01;
      unique case (size_q)
         2'b00: begin
            low_bits  = 3'b000;
            size_mask = 8'h01;
         end
         2'b01: begin
            low_bits  = 3'b001;
            size_mask = 8'h03;
         end
         2'b10: begin
            low_bits  = 3'b011;
            size_mask = 8'h0F;
         end
         2'b11: begin
            low_bits  = 3'b111;
            size_mask = 8'hFF;
         end
      endcase

      misaligned = |(addr_q[2:0] & low_bits);
      // Aligning down keeps every access inside one word; the range
      // limit is a multiple of 8 so it is unaffected by the alignment.
      addr_eff = {addr_q[63:3], addr_q[2:0] & ~low_bits};
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      acc_err = misaligned || (addr_eff >= LIMIT);
`else
      acc_err = (addr_eff >= LIMIT);
`endif
      lane = addr_eff[2:0];
      idx  = addr_eff[IW+2:3];
      word = acc_err ? 64'd0 : mem[idx];

      shifted  = word >> {lane, 3'b000};
      load_val = shifted;
      unique case (size_q)
         2'b00: load_val = uns_q ? {56'd0, shifted[7:0]}
                                 : {{56{shifted[7]}}, shifted[7:0]};
         2'b01: load_val = uns_q ? {48'd0, shifted[15:0]}
                                 : {{48{shifted[15]}}, shifted[15:0]};
         2'b10: load_val = uns_q ? {32'd0, shifted[31:0]}
                                 : {{32{shifted[31]}}, shifted[31:0]};
         2'b11: load_val = shifted;
      endcase

      wmask    = size_mask << lane;
      wdata_sh = wdata_q << {lane, 3'b000};
   end

   // Next-state logic: request capture, wait countdown, access, held response.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               size_d  = bus.req_size;
               write_d = bus.req_write;
               uns_d   = bus.req_unsigned;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: begin
            err_d   = acc_err;
            rdata_d = (write_q || acc_err) ? 64'd0 : load_val;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               rdata_d = 64'd0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Control and response registers; reset drops any transaction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 64'd0;
         size_q  <= 2'b00;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= 64'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         write_q <= write_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Byte-masked store; array contents survive reset, and a store
   // caught by reset in its ACCESS cycle does not commit.
   always_ff @(posedge clock) begin
      if (!reset && state_q == S_ACCESS && write_q && !acc_err) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask[b]) begin
               mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
         end
      end
   end

endmodule
